// File: rtl/id_ex_stage.sv
//------------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register with load-use stall, flush, hold and
//               MEM/WB operand forwarding.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
  parameter int DWIDTH = 32,
  parameter int CTRLW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [31:0]       id_pc_i,
  input  logic [31:0]       id_insn_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic [DWIDTH-1:0] id_imm_i,
  input  logic              id_regwren_i,
  input  logic              id_memren_i,
  input  logic [CTRLW-1:0]  id_ctrl_i,
  input  logic [DWIDTH-1:0] rs1data_i,
  input  logic [DWIDTH-1:0] rs2data_i,
  input  logic [4:0]        mem_rd_i,
  input  logic              mem_regwren_i,
  input  logic [DWIDTH-1:0] mem_data_i,
  input  logic [4:0]        wb_rd_i,
  input  logic              wb_regwren_i,
  input  logic [DWIDTH-1:0] wb_data_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [31:0]       ex_pc_o,
  output logic [31:0]       ex_insn_o,
  output logic [DWIDTH-1:0] ex_imm_o,
  output logic [4:0]        ex_rd_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic              ex_regwren_o,
  output logic              ex_memren_o,
  output logic [CTRLW-1:0]  ex_ctrl_o,
  output logic [DWIDTH-1:0] ex_rs1data_o,
  output logic [DWIDTH-1:0] ex_rs2data_o,
  output logic [15:0]       bubble_cnt_o
);

  localparam logic [31:0] C_NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       insn;
    logic [DWIDTH-1:0] imm;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              regwren;
    logic              memren;
    logic [CTRLW-1:0]  ctrl;
    logic [DWIDTH-1:0] rs1data;
    logic [DWIDTH-1:0] rs2data;
  } ex_t;

  ex_t         ex_q, ex_d, bubble;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic        load_use, cnt_inc;

  function automatic logic [DWIDTH-1:0] fwd_sel(
    input logic [4:0]        idx,
    input logic [DWIDTH-1:0] regval,
    input logic [4:0]        m_rd,
    input logic              m_we,
    input logic [DWIDTH-1:0] m_data,
    input logic [4:0]        w_rd,
    input logic              w_we,
    input logic [DWIDTH-1:0] w_data
  );
    if (idx == 5'd0)                 return '0;
    else if (m_we && (m_rd == idx))  return m_data;
    else if (w_we && (w_rd == idx))  return w_data;
    else                             return regval;
  endfunction

  always_comb begin
    bubble      = '0;
    bubble.insn = C_NOP_INSN;

    load_use = ex_q.valid && ex_q.memren && (ex_q.rd != 5'd0) && id_valid_i &&
               ((id_rs1_i == ex_q.rd) || (id_rs2_i == ex_q.rd));
    // A pending load-use stall is meaningless while reset is asserted.
    stall_o  = hold_i | (load_use & ~flush_i & rst);

    ex_d    = ex_q;
    cnt_inc = 1'b0;
    if (flush_i) begin
      ex_d    = bubble;
      cnt_inc = 1'b1;
    end else if (!hold_i) begin
      if (load_use || !id_valid_i) begin
        ex_d    = bubble;
        cnt_inc = 1'b1;
      end else begin
        ex_d.valid   = 1'b1;
        ex_d.pc      = id_pc_i;
        ex_d.insn    = id_insn_i;
        ex_d.imm     = id_imm_i;
        ex_d.rd      = id_rd_i;
        ex_d.rs1     = id_rs1_i;
        ex_d.rs2     = id_rs2_i;
        ex_d.regwren = id_regwren_i;
        ex_d.memren  = id_memren_i;
        ex_d.ctrl    = id_ctrl_i;
        ex_d.rs1data = rs1data_i;
        ex_d.rs2data = rs2data_i;
      end
    end

    bubble_cnt_d = (cnt_inc && (bubble_cnt_q != 16'hFFFF)) ? bubble_cnt_q + 16'd1
                                                             : bubble_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q         <= bubble;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid_o   = ex_q.valid;
  assign ex_pc_o      = ex_q.pc;
  assign ex_insn_o    = ex_q.insn;
  assign ex_imm_o     = ex_q.imm;
  assign ex_rd_o      = ex_q.rd;
  assign ex_rs1_o     = ex_q.rs1;
  assign ex_rs2_o     = ex_q.rs2;
  assign ex_regwren_o = ex_q.regwren;
  assign ex_memren_o  = ex_q.memren;
  assign ex_ctrl_o    = ex_q.ctrl;
  assign bubble_cnt_o = bubble_cnt_q;

  assign ex_rs1data_o = fwd_sel(ex_q.rs1, ex_q.rs1data, mem_rd_i, mem_regwren_i, mem_data_i,
                                wb_rd_i, wb_regwren_i, wb_data_i);
  assign ex_rs2data_o = fwd_sel(ex_q.rs2, ex_q.rs2data, mem_rd_i, mem_regwren_i, mem_data_i,
                                wb_rd_i, wb_regwren_i, wb_data_i);

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//------------------------------------------------------------------------------
// tb_id_ex_stage : directed and randomized checks of id_ex_stage against a
//                  transaction-level reference model.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_regwren, id_memren, flush, hold;
  logic [31:0] id_pc, id_insn, id_imm, rs1data, rs2data;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [15:0] id_ctrl;
  logic        mem_we, wb_we;
  logic [31:0] mem_data, wb_data;

  logic        stall_o, ex_valid_o, ex_regwren_o, ex_memren_o;
  logic [31:0] ex_pc_o, ex_insn_o, ex_imm_o, ex_rs1data_o, ex_rs2data_o;
  logic [4:0]  ex_rd_o, ex_rs1_o, ex_rs2_o;
  logic [15:0] ex_ctrl_o, bubble_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DWIDTH(32), .CTRLW(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_pc_i(id_pc), .id_insn_i(id_insn),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_imm_i(id_imm),
    .id_regwren_i(id_regwren), .id_memren_i(id_memren), .id_ctrl_i(id_ctrl),
    .rs1data_i(rs1data), .rs2data_i(rs2data),
    .mem_rd_i(mem_rd), .mem_regwren_i(mem_we), .mem_data_i(mem_data),
    .wb_rd_i(wb_rd), .wb_regwren_i(wb_we), .wb_data_i(wb_data),
    .flush_i(flush), .hold_i(hold), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_insn_o(ex_insn_o),
    .ex_imm_o(ex_imm_o), .ex_rd_o(ex_rd_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
    .ex_regwren_o(ex_regwren_o), .ex_memren_o(ex_memren_o), .ex_ctrl_o(ex_ctrl_o),
    .ex_rs1data_o(ex_rs1data_o), .ex_rs2data_o(ex_rs2data_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  // Reference model: the instruction currently sitting in EX plus the bubble tally.
  typedef struct {
    bit        valid;
    bit [31:0] pc, insn, imm, d1, d2;
    bit [4:0]  rd, rs1, rs2;
    bit        regwren, memren;
    bit [15:0] ctrl;
  } mex_t;

  mex_t        m;
  int unsigned mcnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic mex_t m_bubble();
    mex_t b;
    b = '{default: 0};
    b.insn = 32'h13;
    return b;
  endfunction

  function automatic bit m_load_use();
    return m.valid && m.memren && (m.rd != 0) && id_valid &&
           ((id_rs1 == m.rd) || (id_rs2 == m.rd));
  endfunction

  function automatic bit [31:0] m_fwd(input bit [4:0] idx, input bit [31:0] v);
    if (idx == 0) return 32'h0;
    if (mem_we && mem_rd == idx) return mem_data;
    if (wb_we && wb_rd == idx) return wb_data;
    return v;
  endfunction

  task automatic drive_id(input bit v, input bit [31:0] pc, input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit [4:0] rd, input bit memren, input bit [31:0] d1, input bit [31:0] d2);
    id_valid   = v;
    id_pc      = pc;
    id_insn    = pc ^ 32'hA5A5_0033;
    id_imm     = pc + 32'd4;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_rd      = rd;
    id_regwren = 1'b1;
    id_memren  = memren;
    id_ctrl    = pc[15:0] ^ 16'h3C3C;
    rs1data    = d1;
    rs2data    = d2;
  endtask

  // One clock: check combinational outputs, advance the model, check EX state.
  task automatic step();
    mex_t nxt;
    #1;
    check("stall", stall_o, hold | (m_load_use() && !flush && rst));
    check("fwd1_pre", ex_rs1data_o, m_fwd(m.rs1, m.d1));
    check("fwd2_pre", ex_rs2data_o, m_fwd(m.rs2, m.d2));
    nxt = m;
    if (!rst) begin
      nxt  = m_bubble();
      mcnt = 0;
    end else if (flush || (!hold && (m_load_use() || !id_valid))) begin
      nxt = m_bubble();
      if (mcnt < 65535) mcnt++;
    end else if (!hold) begin
      nxt.valid = 1; nxt.pc = id_pc; nxt.insn = id_insn; nxt.imm = id_imm;
      nxt.rd = id_rd; nxt.rs1 = id_rs1; nxt.rs2 = id_rs2;
      nxt.regwren = id_regwren; nxt.memren = id_memren; nxt.ctrl = id_ctrl;
      nxt.d1 = rs1data; nxt.d2 = rs2data;
    end
    @(posedge clk);
    m = nxt;
    #1;
    check("valid", ex_valid_o, m.valid);
    check("pc", ex_pc_o, m.pc);
    check("insn", ex_insn_o, m.insn);
    check("imm", ex_imm_o, m.imm);
    check("rd", ex_rd_o, m.rd);
    check("rs1", ex_rs1_o, m.rs1);
    check("rs2", ex_rs2_o, m.rs2);
    check("regwren", ex_regwren_o, m.regwren);
    check("memren", ex_memren_o, m.memren);
    check("ctrl", ex_ctrl_o, m.ctrl);
    check("bubble_cnt", bubble_cnt_o, mcnt);
    check("fwd1", ex_rs1data_o, m_fwd(m.rs1, m.d1));
    check("fwd2", ex_rs2data_o, m_fwd(m.rs2, m.d2));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; hold = 1'b0;
    mem_rd = 0; mem_we = 0; mem_data = 0;
    wb_rd = 0; wb_we = 0; wb_data = 0;
    drive_id(1, 32'h40, 5'd1, 5'd2, 5'd3, 0, 32'h1, 32'h2);
    @(posedge clk);
    #1;
    m = m_bubble();
    mcnt = 0;

    // Reset held two cycles with a valid instruction waiting
    step(); step();
    check("rst_valid", ex_valid_o, 1'b0);
    check("rst_insn", ex_insn_o, 32'h13);
    check("rst_cnt", bubble_cnt_o, 16'd0);
    check("rst_stall", stall_o, 1'b0);

    // Capture after release
    rst = 1'b1;
    drive_id(1, 32'h100, 5'd1, 5'd2, 5'd3, 0, 32'h5, 32'h9);
    step();
    check("cap_pc", ex_pc_o, 32'h100);
    check("cap_rs1data", ex_rs1data_o, 32'h5);
    check("cap_rd", ex_rd_o, 5'd3);
    check("cap_valid", ex_valid_o, 1'b1);

    // Load into x5, consumer of x5 behind it
    drive_id(1, 32'h104, 5'd2, 5'd0, 5'd5, 1, 32'h0, 32'h0);
    step();
    drive_id(1, 32'h108, 5'd5, 5'd6, 5'd7, 0, 32'hDEAD, 32'h66);
    #1;
    check("lu_stall", stall_o, 1'b1);
    step();
    check("lu_bubble_valid", ex_valid_o, 1'b0);
    check("lu_bubble_cnt", bubble_cnt_o, 16'd1);

    // Consumer enters EX while the load sits in WB
    step();
    wb_rd = 5'd5; wb_we = 1'b1; wb_data = 32'hAA;
    #1;
    check("lu_wb_fwd", ex_rs1data_o, 32'hAA);

    // MEM beats WB; x0 never forwarded
    drive_id(1, 32'h10C, 5'd7, 5'd0, 5'd8, 0, 32'h33, 32'h44);
    step();
    mem_rd = 5'd7; mem_we = 1'b1; mem_data = 32'h11;
    wb_rd = 5'd7; wb_data = 32'h22;
    #1;
    check("fwd_prio", ex_rs1data_o, 32'h11);
    drive_id(1, 32'h110, 5'd0, 5'd0, 5'd9, 0, 32'h55, 32'h56);
    mem_rd = 5'd0; wb_rd = 5'd0;
    step();
    check("fwd_x0", ex_rs1data_o, 32'h0);

    // Flush wins over load-use
    mem_we = 1'b0; wb_we = 1'b0;
    drive_id(1, 32'h114, 5'd1, 5'd0, 5'd4, 1, 32'h0, 32'h0);
    step();
    drive_id(1, 32'h118, 5'd4, 5'd1, 5'd10, 0, 32'h7, 32'h8);
    flush = 1'b1;
    #1;
    check("flush_stall", stall_o, 1'b0);
    step();
    check("flush_valid", ex_valid_o, 1'b0);
    check("flush_insn", ex_insn_o, 32'h13);
    check("flush_cnt", bubble_cnt_o, 16'd2);

    // Hold freezes EX and the tally
    flush = 1'b0;
    drive_id(1, 32'h200, 5'd3, 5'd4, 5'd11, 0, 32'h77, 32'h88);
    step();
    hold = 1'b1;
    drive_id(1, 32'h300, 5'd5, 5'd6, 5'd12, 0, 32'h99, 32'hAB);
    step();
    check("hold_pc", ex_pc_o, 32'h200);
    check("hold_cnt", bubble_cnt_o, 16'd2);
    hold = 1'b0;

    // Randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 500; i++) begin
      rst    = ($urandom_range(0, 99) >= 3);
      flush  = ($urandom_range(0, 99) < 10);
      hold   = ($urandom_range(0, 99) < 15);
      drive_id($urandom_range(0, 99) < 80, $urandom, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom_range(0, 99) < 35, $urandom, $urandom);
      id_regwren = 1'($urandom);
      mem_rd   = 5'($urandom_range(0, 7));
      mem_we   = 1'($urandom);
      mem_data = $urandom;
      wb_rd    = 5'($urandom_range(0, 7));
      wb_we    = 1'($urandom);
      wb_data  = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning operand/data width.
REQ-002 The block SHALL have parameter CTRLW, default 16, meaning width of the opaque execute-control bundle.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge.
REQ-004 Port rst, input, 1: reset, synchronous and active-low.
REQ-005 Port id_valid_i, input, 1: decode holds a valid instruction.
REQ-006 Ports id_pc_i and id_insn_i, input, 32 each: decode PC and instruction word.
REQ-007 Ports id_rs1_i, id_rs2_i and id_rd_i, input, 5 each: decoded register indices.
REQ-008 Port id_imm_i, input, DWIDTH: decoded immediate.
REQ-009 Ports id_regwren_i and id_memren_i, input, 1 each: writes rd; is a load.
REQ-010 Port id_ctrl_i, input, CTRLW: execute-control bundle, passed through unmodified.
REQ-011 Ports rs1data_i and rs2data_i, input, DWIDTH each: register-file read data, valid before posedge.
REQ-012 Ports mem_rd_i (5), mem_regwren_i (1) and mem_data_i (DWIDTH), input: MEM-stage producer.
REQ-013 Ports wb_rd_i (5), wb_regwren_i (1) and wb_data_i (DWIDTH), input: WB-stage producer.
REQ-014 Port flush_i, input, 1: branch/jump redirect resolved in EX.
REQ-015 Port hold_i, input, 1: downstream freeze request, e.g. a memory wait.
REQ-016 Port stall_o, output, 1: IF/ID SHALL hold this cycle.
REQ-017 Ports ex_valid_o (1), ex_pc_o (32), ex_insn_o (32), ex_imm_o (DWIDTH), ex_rd_o (5), ex_rs1_o (5), ex_rs2_o (5), ex_regwren_o (1), ex_memren_o (1) and ex_ctrl_o (CTRLW), output: registered EX-stage fields.
REQ-018 Ports ex_rs1data_o and ex_rs2data_o, output, DWIDTH each: forwarded EX operands.
REQ-019 Port bubble_cnt_o, output, 16: saturating count of bubbles inserted.

Function
REQ-020 Load-use hazard SHALL be: ex_valid_o & ex_memren_o & ex_rd_o!=0 & id_valid_i & (id_rs1_i==ex_rd_o | id_rs2_i==ex_rd_o).
REQ-021 stall_o SHALL be combinational: hold_i | (load_use & !flush_i).
REQ-022 Posedge update priority SHALL be: reset > flush_i > hold_i > load_use > capture.
REQ-023 On flush_i the EX register SHALL become a bubble: valid=0, regwren=0, memren=0, insn=0x00000013, other fields 0.
REQ-024 On hold_i without flush_i, all EX registers SHALL keep their values.
REQ-025 On load_use, the EX register SHALL become a bubble as in REQ-023.
REQ-026 On capture, all id_* fields and rs1data_i/rs2data_i SHALL be registered; ex_valid_o SHALL equal id_valid_i.
REQ-027 If id_valid_i=0 at capture, the EX register SHALL load a bubble.
REQ-028 Capture latency SHALL be one cycle.
REQ-029 ex_rs1data_o SHALL be combinational with priority MEM > WB > registered.
REQ-030 ex_rs1data_o SHALL select mem_data_i when mem_regwren_i & mem_rd_i==ex_rs1_o & ex_rs1_o!=0.
REQ-031 Otherwise ex_rs1data_o SHALL select wb_data_i when wb_regwren_i & wb_rd_i==ex_rs1_o & ex_rs1_o!=0.
REQ-032 Otherwise ex_rs1data_o SHALL output the registered value; ex_rs2data_o SHALL follow the same rules using ex_rs2_o.
REQ-033 Index x0 SHALL never be forwarded; an operand whose index is 0 SHALL read 0.
REQ-034 bubble_cnt_o SHALL increment on each posedge that loads a bubble via REQ-023, REQ-025 or REQ-027, and SHALL saturate at 0xFFFF.
REQ-035 A hold cycle SHALL NOT increment bubble_cnt_o.

Reset
REQ-036 While rst=0 at posedge: all ex_* registers 0, except ex_insn_o=0x00000013.
REQ-037 While rst=0 at posedge: bubble_cnt_o SHALL be 0.
REQ-038 stall_o SHALL be 0 during reset unless hold_i=1.
REQ-039 Reset asserted mid-stall or mid-hold SHALL override both.
REQ-040 The first capture after reset release SHALL occur on the next posedge with rst=1.

Verification
REQ-041 Reset: rst=0 for 2 cycles with id_valid_i=1 -> ex_valid_o=0, ex_insn_o=0x13, bubble_cnt_o=0, stall_o=0.
REQ-042 Capture: id_pc=0x100, rs1data=0x5, rd=3 -> next cycle ex_pc_o=0x100, ex_rs1data_o=5, ex_rd_o=3, ex_valid_o=1.
REQ-043 Load-use: EX holds lw x5, ID holds add rs1=x5 -> stall_o=1; next cycle EX is a bubble, bubble_cnt_o=1.
REQ-044 Load-use resolved: load in WB with wb_data=0xAA, consumer then in EX -> ex_rs1data_o=0xAA.
REQ-045 Forward priority: mem_rd=wb_rd=ex_rs1_o=7, mem_data=0x11, wb_data=0x22 -> ex_rs1data_o=0x11; with ex_rs1_o=0 -> ex_rs1data_o=0.
REQ-046 Flush vs stall and hold: flush_i=1 with load_use -> stall_o=0, EX bubble; hold_i=1 alone -> EX unchanged and bubble_cnt_o unchanged.
